zicfilp_commit_guard: RTL and testbench



---
 rtl/zicfilp_commit_guard.sv | 157 +++++++++++++++
 tb/tb_zicfilp_commit_guard.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zicfilp_commit_guard.sv
// rtl/zicfilp_commit_guard.sv - Zicfilp landing-pad enforcer for the commit stage

package config_pkg;
    // Minimal core configuration; only the landing-pad control is consumed here.
    typedef struct packed {
        logic DisableZicfilp;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{DisableZicfilp: 1'b0};
endpackage

module zicfilp_commit_guard #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned NrPorts   = 2,
    parameter int unsigned LabelBits = 20,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [1:0]                   priv_lvl_i,
    input  logic                         lpe_m_i,
    input  logic                         lpe_s_i,
    input  logic                         lpe_u_i,
    input  logic [NrPorts-1:0]           valid_i,
    input  logic [NrPorts-1:0]           ex_i,
    input  logic [NrPorts-1:0]           is_lpad_i,
    input  logic [NrPorts-1:0]           is_ijump_i,
    input  logic [NrPorts-1:0]           wr_x7_i,
    input  logic [NrPorts*LabelBits-1:0] result_i,
    input  logic [NrPorts-1:0]           ack_i,
    input  logic                         trap_i,
    input  logic                         trap_to_m_i,
    input  logic                         mret_i,
    input  logic                         sret_i,
    input  logic                         cnt_clr_i,
    output logic [NrPorts-1:0]           viol_o,
    output logic [NrPorts-1:0]           block_o,
    output logic                         elp_o,
    output logic [LabelBits-1:0]         lpl_o,
    output logic                         mpelp_o,
    output logic                         spelp_o,
    output logic [CntWidth-1:0]          viol_cnt_o
);

    logic                 elp_q, elp_d;
    logic [LabelBits-1:0] lpl_q, lpl_d;
    logic                 mpelp_q, mpelp_d;
    logic                 spelp_q, spelp_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;

    logic                 lpe;
    logic                 elp_run;
    logic [LabelBits-1:0] lpl_run;
    logic                 stopped;
    logic                 live;
    logic                 fault;
    logic [LabelBits-1:0] label;

    // Effective landing-pad enable for the current mode. During an xRET cycle the
    // CSR file already presents the return privilege, so this also selects the
    // enable of the mode being returned to. Reserved encoding 2 follows M.
    always_comb begin
        case (priv_lvl_i)
            2'b00:   lpe = lpe_u_i;
            2'b01:   lpe = lpe_s_i;
            default: lpe = lpe_m_i;
        endcase
        lpe = lpe & ~CVA6Cfg.DisableZicfilp;
    end

    // Walk the commit ports in program order, threading ELP/LPL through them so a
    // JALR on an earlier port arms the check for a later port in the same cycle.
    always_comb begin
        elp_run = elp_q;
        lpl_run = lpl_q;
        stopped = 1'b0;
        live    = 1'b0;
        fault   = 1'b0;
        label   = '0;
        viol_o  = '0;
        block_o = '0;
        for (int i = 0; i < int'(NrPorts); i++) begin
            label      = result_i[i*LabelBits +: LabelBits];
            block_o[i] = stopped;
            live       = valid_i[i] & ~ex_i[i] & ~stopped;
            fault      = live & lpe & elp_run &
                         (~is_lpad_i[i] | ((label != '0) & (label != lpl_run)));
            viol_o[i]  = fault;
            if (live && !fault && ack_i[i]) begin
                // A clean LPAD consumes the armed ELP; otherwise an indirect jump arms it.
                if (lpe) begin
                    elp_run = elp_run ? 1'b0 : is_ijump_i[i];
                end
                if (wr_x7_i[i]) begin
                    lpl_run = label;
                end
            end
            stopped = stopped | ~valid_i[i] | ex_i[i] | fault | ~ack_i[i];
        end
    end

    // Architectural next state: trap saves ELP, xRET restores it, else commit result.
    always_comb begin
        elp_d   = elp_run;
        lpl_d   = lpl_run;
        mpelp_d = mpelp_q;
        spelp_d = spelp_q;
        if (trap_i) begin
            elp_d = 1'b0;
            if (trap_to_m_i) begin
                mpelp_d = elp_run;
            end else begin
                spelp_d = elp_run;
            end
        end else if (mret_i) begin
            elp_d   = mpelp_q & lpe;
            mpelp_d = 1'b0;
        end else if (sret_i) begin
            elp_d   = spelp_q & lpe;
            spelp_d = 1'b0;
        end
    end

    // Saturating count of cycles with at least one fault; clear takes precedence.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if ((|viol_o) && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            elp_q   <= 1'b0;
            lpl_q   <= '0;
            mpelp_q <= 1'b0;
            spelp_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            elp_q   <= elp_d;
            lpl_q   <= lpl_d;
            mpelp_q <= mpelp_d;
            spelp_q <= spelp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign elp_o      = elp_q;
    assign lpl_o      = lpl_q;
    assign mpelp_o    = mpelp_q;
    assign spelp_o    = spelp_q;
    assign viol_cnt_o = cnt_q;

endmodule

// File: tb/tb_zicfilp_commit_guard.sv
// tb/tb_zicfilp_commit_guard.sv - scoreboard bench for zicfilp_commit_guard

module tb_zicfilp_commit_guard;

    localparam int NP = 2;
    localparam int LB = 20;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    priv;
    logic          lpe_m, lpe_s, lpe_u;
    logic [NP-1:0] valid, ex, lpad, ijump, wrx7, ack;
    logic [NP*LB-1:0] result;
    logic          trap, trap_to_m, mret, sret, clr;
    logic [NP-1:0] viol, block;
    logic          elp, mpelp, spelp;
    logic [LB-1:0] lpl;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    zicfilp_commit_guard #(.NrPorts(NP), .LabelBits(LB), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_i(rst), .priv_lvl_i(priv),
        .lpe_m_i(lpe_m), .lpe_s_i(lpe_s), .lpe_u_i(lpe_u),
        .valid_i(valid), .ex_i(ex), .is_lpad_i(lpad), .is_ijump_i(ijump),
        .wr_x7_i(wrx7), .result_i(result), .ack_i(ack),
        .trap_i(trap), .trap_to_m_i(trap_to_m), .mret_i(mret), .sret_i(sret),
        .cnt_clr_i(clr), .viol_o(viol), .block_o(block), .elp_o(elp),
        .lpl_o(lpl), .mpelp_o(mpelp), .spelp_o(spelp), .viol_cnt_o(cnt)
    );

    typedef struct {
        logic [NP-1:0] v;
        logic [NP-1:0] b;
        logic          e;
        logic [LB-1:0] l;
        logic          mp;
        logic          sp;
        logic [CW-1:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference architectural state
    bit          m_elp, m_mpelp, m_spelp;
    logic [LB-1:0] m_lpl;
    int          m_cnt;

    function automatic bit mode_lpe();
        case (priv)
            2'd0: return lpe_u;
            2'd1: return lpe_s;
            default: return lpe_m;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    // Evaluate the current cycle from the ISA rules, push the expectation, advance the model.
    task automatic step();
        exp_t x;
        bit en, e_run, halted, any;
        logic [LB-1:0] l_run, lab;
        en = mode_lpe();
        e_run = m_elp;
        l_run = m_lpl;
        halted = 0;
        x.v = '0;
        x.b = '0;
        for (int i = 0; i < NP; i++) begin
            x.b[i] = halted;
            lab = result[i*LB +: LB];
            if (halted) continue;
            if (!valid[i] || ex[i]) begin halted = 1; continue; end
            if (en && e_run && (!lpad[i] || (lab != 0 && lab != l_run))) begin
                x.v[i] = 1'b1;
                halted = 1;
                continue;
            end
            if (!ack[i]) begin halted = 1; continue; end
            if (en) begin
                if (e_run) e_run = 0;
                else if (ijump[i]) e_run = 1;
            end
            if (wrx7[i]) l_run = lab;
        end
        x.e  = m_elp;
        x.l  = m_lpl;
        x.mp = m_mpelp;
        x.sp = m_spelp;
        x.c  = CW'(m_cnt);
        exp_q.push_back(x);
        any = (x.v != 0);
        if (rst) begin
            m_elp = 0; m_lpl = '0; m_mpelp = 0; m_spelp = 0; m_cnt = 0;
        end else begin
            m_lpl = l_run;
            if (clr) m_cnt = 0;
            else if (any && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
            if (trap) begin
                if (trap_to_m) m_mpelp = e_run;
                else m_spelp = e_run;
                m_elp = 0;
            end else if (mret) begin
                m_elp = m_mpelp & en;
                m_mpelp = 0;
            end else if (sret) begin
                m_elp = m_spelp & en;
                m_spelp = 0;
            end else begin
                m_elp = e_run;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare whatever the DUT presents mid-cycle against the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("viol_o",     32'(viol),  32'(x.v));
                chk("block_o",    32'(block), 32'(x.b));
                chk("elp_o",      32'(elp),   32'(x.e));
                chk("lpl_o",      32'(lpl),   32'(x.l));
                chk("mpelp_o",    32'(mpelp), 32'(x.mp));
                chk("spelp_o",    32'(spelp), 32'(x.sp));
                chk("viol_cnt_o", 32'(cnt),   32'(x.c));
            end
        end
    end

    task automatic idle();
        rst = 0; valid = '0; ex = '0; lpad = '0; ijump = '0; wrx7 = '0; ack = '0;
        result = '0; trap = 0; trap_to_m = 0; mret = 0; sret = 0; clr = 0;
    endtask

    task automatic port(input int i, input bit lp, input bit ij, input bit wx,
                        input logic [LB-1:0] res, input bit a);
        valid[i] = 1; lpad[i] = lp; ijump[i] = ij; wrx7[i] = wx;
        result[i*LB +: LB] = res; ack[i] = a;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1; priv = 2'd3; lpe_m = 1; lpe_s = 1; lpe_u = 1;
        repeat (2) @(posedge clk);
        #1;
        m_elp = 0; m_lpl = '0; m_mpelp = 0; m_spelp = 0; m_cnt = 0;
        step();                                 // reset held: reset state visible

        // JALR then LPAD label 0 in the same cycle
        idle(); port(0, 0, 1, 0, 0, 1); port(1, 1, 0, 0, 0, 1); step();
        idle(); step();
        // LPL=5, JALR, mismatching LPAD, then trap to M
        idle(); port(0, 0, 0, 1, 20'h5, 1); step();
        idle(); port(0, 0, 1, 0, 0, 1); step();
        idle(); port(0, 1, 0, 0, 20'h6, 1); port(1, 0, 0, 0, 0, 1); step();
        idle(); trap = 1; trap_to_m = 1; step();
        // MRET to S with lpe_s=1, then again with lpe_s=0
        idle(); priv = 2'd1; mret = 1; step();
        idle(); priv = 2'd3; step();
        idle(); port(0, 0, 1, 0, 0, 1); step();
        idle(); trap = 1; trap_to_m = 1; step();
        idle(); priv = 2'd1; lpe_s = 0; mret = 1; step();
        idle(); priv = 2'd3; lpe_s = 1; step();
        // Landing pads disabled: JALR then ADD, then x7 write
        idle(); lpe_m = 0; port(0, 0, 1, 0, 0, 1); step();
        idle(); port(0, 0, 0, 0, 0, 1); step();
        idle(); port(0, 0, 0, 1, 20'hABCDE, 1); step();
        idle(); lpe_m = 1; step();
        // Excepted port 0 blocks port 1; un-acked JALR leaves ELP alone
        idle(); valid[0] = 1; ex[0] = 1; port(1, 1, 0, 0, 0, 1); step();
        idle(); port(0, 0, 1, 0, 0, 0); step();
        // Counter saturation and clear-with-violation
        idle(); port(0, 0, 1, 0, 0, 1); step();
        for (int k = 0; k < 4; k++) begin
            idle(); port(0, 0, 0, 0, 0, 1); step();
        end
        idle(); port(0, 0, 0, 0, 0, 1); clr = 1; step();
        idle(); step();
        // Reset in the middle of a JALR sequence
        idle(); port(0, 0, 1, 1, 20'h3, 1); step();
        idle(); rst = 1; port(0, 0, 1, 0, 0, 1); step();
        idle(); step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            priv  = 2'($urandom_range(0, 3));
            lpe_m = ($urandom_range(0, 9) != 0);
            lpe_s = ($urandom_range(0, 9) != 0);
            lpe_u = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NP; i++) begin
                valid[i] = ($urandom_range(0, 9) != 0);
                ex[i]    = ($urandom_range(0, 15) == 0);
                lpad[i]  = $urandom_range(0, 1);
                ijump[i] = ($urandom_range(0, 9) < 3);
                wrx7[i]  = ($urandom_range(0, 3) == 0);
                ack[i]   = ($urandom_range(0, 9) < 8);
                result[i*LB +: LB] = ($urandom_range(0, 7) == 0) ?
                                     LB'($urandom) : LB'($urandom_range(0, 3));
            end
            trap      = ($urandom_range(0, 19) == 0);
            trap_to_m = $urandom_range(0, 1);
            mret      = ($urandom_range(0, 19) == 0);
            sret      = ($urandom_range(0, 19) == 0);
            clr       = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        idle();
        step();

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
